fetch_sequencer: RTL and testbench

- Sequences instruction fetch for the CPU front end.
- Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Presents each fetched instruction to decode over a valid/ready handshake.
- Applies branch/jump redirects from decode, including redirects that arrive while a memory read is in flight. Enforces the program address window (BOOT_ADDR..END_ADDR) with wrap-around.

---
 rtl/fetch_sequencer.sv | 134 +++++++++++++
 tb/tb_fetch_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch front end.
//   Owns the fetch PC. Issues one word read at a time over imem_req/imem_ack.
//   Holds each fetched word for decode on if_valid/if_ready.
//   Applies decode redirects. A redirect that arrives mid-read is parked in
//   pend/pend_addr. The read then completes, its data is dropped, and the
//   target is fetched next.
//   Fetch addresses stay within [BOOT_ADDR, END_ADDR]. Sequential fetch
//   wraps back to BOOT_ADDR. An out-of-window redirect also goes to
//   BOOT_ADDR and raises addr_err.
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   en                  fetch enable (never aborts a read already in flight)
//   imem_req/addr       read request and word-aligned address (stable until ack)
//   imem_ack/rdata      read completion and data
//   if_valid/ready      instruction handshake toward decode
//   if_instr/if_pc      fetched word and the address it came from
//   redirect/_addr      single-cycle branch/jump pulse and its target
//   addr_err            one-cycle pulse: redirect target was out of window
//   wrap_cnt            saturating count of sequential window wraps
module fetch_sequencer #(
  parameter logic [31:0] BOOT_ADDR = 32'h31B0,
  parameter logic [31:0] END_ADDR  = 32'h35AC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        addr_err,
  output logic [7:0]  wrap_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        pend;
  logic [31:0] pend_addr;

  // Redirect target: force word alignment, then clamp out-of-window
  // targets to the boot address.
  logic [31:0] rd_al, rd_tgt;
  logic        rd_oob;
  assign rd_al  = redirect_addr & ~32'h3;
  assign rd_oob = (rd_al < BOOT_ADDR) || (rd_al > END_ADDR);
  assign rd_tgt = rd_oob ? BOOT_ADDR : rd_al;

  // Sequential successor of the address being read.
  logic        seq_wrap;
  logic [31:0] seq_next;
  assign seq_wrap = imem_addr >= END_ADDR;
  assign seq_next = seq_wrap ? BOOT_ADDR : imem_addr + 32'd4;

  // A fresh redirect wins over one parked earlier in the same read.
  logic [31:0] redo_addr;
  assign redo_addr = redirect ? rd_tgt : pend_addr;

  // Address to launch when leaving HOLD.
  logic [31:0] hold_next;
  assign hold_next = redirect ? rd_tgt : pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= BOOT_ADDR;
      pend      <= 1'b0;
      pend_addr <= '0;
      imem_req  <= 1'b0;
      imem_addr <= BOOT_ADDR;
      if_valid  <= 1'b0;
      if_instr  <= '0;
      if_pc     <= '0;
      addr_err  <= 1'b0;
      wrap_cnt  <= '0;
    end else begin
      addr_err <= redirect && rd_oob;
      case (state)
        IDLE: begin
          if (redirect) pc <= rd_tgt;
          if (en) begin
            state     <= FETCH;
            imem_req  <= 1'b1;
            imem_addr <= hold_next;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            if (redirect || pend) begin
              // Returned data belongs to a stale path. Drop it and
              // re-issue at the redirect target without lowering req.
              pc        <= redo_addr;
              imem_addr <= redo_addr;
              pend      <= 1'b0;
            end else begin
              if_instr <= imem_rdata;
              if_pc    <= imem_addr;
              if_valid <= 1'b1;
              pc       <= seq_next;
              imem_req <= 1'b0;
              state    <= HOLD;
              if (seq_wrap && wrap_cnt != 8'hFF) wrap_cnt <= wrap_cnt + 8'd1;
            end
          end else if (redirect) begin
            pend      <= 1'b1;
            pend_addr <= rd_tgt;
          end
        end
        HOLD: begin
          if (redirect || if_ready) begin
            if_valid <= 1'b0;
            pc       <= hold_next;
            if (en) begin
              state     <= FETCH;
              imem_req  <= 1'b1;
              imem_addr <= hold_next;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  localparam logic [31:0] BOOT = 32'h31B0;
  localparam logic [31:0] ENDA = 32'h35AC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, imem_ack = 1'b0, if_ready = 1'b0, redirect = 1'b0;
  logic [31:0] imem_rdata = '0, redirect_addr = '0;
  logic        imem_req, if_valid, addr_err;
  logic [31:0] imem_addr, if_instr, if_pc;
  logic [7:0]  wrap_cnt;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .addr_err(addr_err), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, sample 1 time unit after the edge.
  task automatic step(input logic e, input logic a, input logic [31:0] d,
                      input logic r, input logic rd, input logic [31:0] ra);
    en = e; imem_ack = a; imem_rdata = d; if_ready = r;
    redirect = rd; redirect_addr = ra;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    en = 0; imem_ack = 0; if_ready = 0; redirect = 0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   32'(imem_req), 32'd0);
    chk({tag, "_addr"},  imem_addr, BOOT);
    chk({tag, "_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_instr"}, if_instr, 32'd0);
    chk({tag, "_pc"},    if_pc, 32'd0);
    chk({tag, "_err"},   32'(addr_err), 32'd0);
    chk({tag, "_wrap"},  32'(wrap_cnt), 32'd0);
  endtask

  // Reference rules, written directly from the address-window definitions.
  function automatic logic [31:0] f_next(input logic [31:0] p);
    return (p >= ENDA) ? BOOT : p + 32'd4;
  endfunction
  function automatic bit f_oob(input logic [31:0] a);
    logic [31:0] t;
    t = {a[31:2], 2'b00};
    return (t < BOOT) || (t > ENDA);
  endfunction
  function automatic logic [31:0] f_tgt(input logic [31:0] a);
    logic [31:0] t;
    t = {a[31:2], 2'b00};
    return f_oob(a) ? BOOT : t;
  endfunction

  typedef struct {
    logic        en, ack;
    logic [31:0] rdata;
    logic        rdy, red;
    logic [31:0] raddr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_instr;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(logic e, logic a, logic [31:0] d, logic r, logic rd,
                              logic [31:0] ra, logic q, logic [31:0] qa, logic v,
                              logic [31:0] vp, logic [31:0] vi, logic er);
    vec_t t;
    t.en = e; t.ack = a; t.rdata = d; t.rdy = r; t.red = rd; t.raddr = ra;
    t.e_req = q; t.e_addr = qa; t.e_valid = v; t.e_pc = vp; t.e_instr = vi; t.e_err = er;
    return t;
  endfunction

  vec_t tbl[20];

  // Random-phase model state
  logic [31:0] mpc, m_ipc, m_iinstr;
  int          mwrap;
  bit          taint;

  initial begin
    //           en ack rdata        rdy red raddr     | req addr      vld pc        instr        err
    tbl[0]  = mk(1, 0, 32'h0,        0, 0, 32'h0,      1, 32'h31B0, 0, 32'h0,    32'h0,       0);
    tbl[1]  = mk(1, 1, 32'hA0,       0, 0, 32'h0,      0, 32'h0,    1, 32'h31B0, 32'hA0,      0);
    tbl[2]  = mk(1, 0, 32'h0,        1, 0, 32'h0,      1, 32'h31B4, 0, 32'h0,    32'h0,       0);
    tbl[3]  = mk(1, 1, 32'hA1,       0, 0, 32'h0,      0, 32'h0,    1, 32'h31B4, 32'hA1,      0);
    tbl[4]  = mk(1, 0, 32'h0,        1, 0, 32'h0,      1, 32'h31B8, 0, 32'h0,    32'h0,       0);
    tbl[5]  = mk(1, 1, 32'hA2,       0, 0, 32'h0,      0, 32'h0,    1, 32'h31B8, 32'hA2,      0);
    tbl[6]  = mk(1, 0, 32'h0,        1, 0, 32'h0,      1, 32'h31BC, 0, 32'h0,    32'h0,       0);
    tbl[7]  = mk(1, 0, 32'h0,        0, 1, 32'h3203,   1, 32'h31BC, 0, 32'h0,    32'h0,       0);
    tbl[8]  = mk(1, 0, 32'h0,        0, 0, 32'h0,      1, 32'h31BC, 0, 32'h0,    32'h0,       0);
    tbl[9]  = mk(1, 1, 32'hDEAD,     0, 0, 32'h0,      1, 32'h3200, 0, 32'h0,    32'h0,       0);
    tbl[10] = mk(1, 1, 32'hB0,       0, 0, 32'h0,      0, 32'h0,    1, 32'h3200, 32'hB0,      0);
    tbl[11] = mk(1, 0, 32'h0,        1, 1, 32'h1000,   1, 32'h31B0, 0, 32'h0,    32'h0,       1);
    tbl[12] = mk(1, 0, 32'h0,        0, 0, 32'h0,      1, 32'h31B0, 0, 32'h0,    32'h0,       0);
    tbl[13] = mk(1, 1, 32'hC0,       0, 0, 32'h0,      0, 32'h0,    1, 32'h31B0, 32'hC0,      0);
    tbl[14] = mk(0, 0, 32'h0,        1, 0, 32'h0,      0, 32'h0,    0, 32'h0,    32'h0,       0);
    tbl[15] = mk(0, 1, 32'hEE,       0, 0, 32'h0,      0, 32'h0,    0, 32'h0,    32'h0,       0);
    tbl[16] = mk(1, 0, 32'h0,        0, 0, 32'h0,      1, 32'h31B4, 0, 32'h0,    32'h0,       0);
    tbl[17] = mk(0, 0, 32'h0,        0, 0, 32'h0,      1, 32'h31B4, 0, 32'h0,    32'h0,       0);
    tbl[18] = mk(0, 1, 32'hD0,       0, 0, 32'h0,      0, 32'h0,    1, 32'h31B4, 32'hD0,      0);
    tbl[19] = mk(1, 0, 32'h0,        1, 0, 32'h0,      1, 32'h31B8, 0, 32'h0,    32'h0,       0);

    do_reset();
    chk_reset("rst0");

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].en, tbl[i].ack, tbl[i].rdata, tbl[i].rdy, tbl[i].red, tbl[i].raddr);
      chk($sformatf("v%0d_req", i),   32'(imem_req), 32'(tbl[i].e_req));
      chk($sformatf("v%0d_valid", i), 32'(if_valid), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d_err", i),   32'(addr_err), 32'(tbl[i].e_err));
      if (tbl[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
      if (tbl[i].e_valid) begin
        chk($sformatf("v%0d_pc", i),    if_pc, tbl[i].e_pc);
        chk($sformatf("v%0d_instr", i), if_instr, tbl[i].e_instr);
      end
    end

    // Decode stalls five cycles: the held instruction must not move.
    step(1, 1, 32'h5A5A, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 32'h0, 0, 0, 0);
      chk($sformatf("stall%0d_valid", i), 32'(if_valid), 32'd1);
      chk($sformatf("stall%0d_pc", i),    if_pc, 32'h31B8);
      chk($sformatf("stall%0d_instr", i), if_instr, 32'h5A5A);
      chk($sformatf("stall%0d_req", i),   32'(imem_req), 32'd0);
    end
    step(1, 0, 32'h0, 1, 0, 0);
    chk("stall_rel_addr", imem_addr, 32'h31BC);

    // Wrap at the top of the window.
    step(1, 1, 32'hBAD, 0, 1, ENDA);
    chk("wrap_redo_addr", imem_addr, ENDA);
    chk("wrap_before", 32'(wrap_cnt), 32'd0);
    step(1, 1, 32'h77, 0, 0, 0);
    chk("wrap_pc", if_pc, ENDA);
    step(1, 0, 32'h0, 1, 0, 0);
    chk("wrap_addr", imem_addr, BOOT);
    chk("wrap_after", 32'(wrap_cnt), 32'd1);

    // Asynchronous reset in the middle of a read.
    chk("mid_req_pre", 32'(imem_req), 32'd1);
    #1 rst = 1'b0;
    #1 chk("async_req", 32'(imem_req), 32'd0);
    chk_reset("rst1");
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    step(1, 0, 32'h0, 0, 0, 0);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, BOOT);

    // Randomized run against a transaction-level model.
    do_reset();
    mpc = BOOT; mwrap = 0; taint = 0; m_ipc = 0; m_iinstr = 0;
    for (int c = 0; c < 1500; c++) begin
      logic p_req, p_valid;
      logic [31:0] p_addr;
      logic i_en, i_ack, i_rdy, i_red;
      logic [31:0] i_d, i_ra;
      logic e_req, e_valid, e_err, e_start, e_stable;
      int sel;

      p_req = imem_req; p_valid = if_valid; p_addr = imem_addr;
      i_en  = ($urandom_range(0, 9) != 0);
      i_ack = ($urandom_range(0, 2) == 0);
      i_rdy = ($urandom_range(0, 1) == 0);
      i_red = ($urandom_range(0, 6) == 0);
      i_d   = $urandom;
      sel   = $urandom_range(0, 2);
      if (sel == 0)      i_ra = $urandom;
      else if (sel == 1) i_ra = BOOT + $urandom_range(0, ENDA - BOOT + 3);
      else               i_ra = ENDA - $urandom_range(0, 12);

      e_err = i_red && f_oob(i_ra);
      e_start = 0; e_stable = 0; e_valid = 0; e_req = 0;
      if (p_req) begin
        if (i_ack) begin
          if (!taint && !i_red) begin
            e_valid = 1; m_ipc = p_addr; m_iinstr = i_d;
            if (p_addr >= ENDA && mwrap < 255) mwrap++;
            mpc = f_next(p_addr);
          end else begin
            e_req = 1; e_start = 1;
            if (i_red) mpc = f_tgt(i_ra);
          end
        end else begin
          e_req = 1; e_stable = 1;
          if (i_red) begin mpc = f_tgt(i_ra); taint = 1; end
        end
      end else if (p_valid) begin
        if (i_red || i_rdy) begin
          if (i_red) mpc = f_tgt(i_ra);
          e_req = i_en; e_start = i_en;
        end else begin
          e_valid = 1;
        end
      end else begin
        if (i_red) mpc = f_tgt(i_ra);
        e_req = i_en; e_start = i_en;
      end

      step(i_en, i_ack, i_d, i_rdy, i_red, i_ra);
      chk("r_req",   32'(imem_req), 32'(e_req));
      chk("r_valid", 32'(if_valid), 32'(e_valid));
      chk("r_err",   32'(addr_err), 32'(e_err));
      chk("r_wrap",  32'(wrap_cnt), 32'(mwrap));
      if (e_valid) begin
        chk("r_pc", if_pc, m_ipc);
        chk("r_instr", if_instr, m_iinstr);
      end
      if (e_start) begin
        chk("r_start_addr", imem_addr, mpc);
        taint = 0;
      end
      if (e_stable) chk("r_stable_addr", imem_addr, p_addr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
